posit_encoder_16: RTL and testbench
===================================

POSIT_ENCODER_16 -- requirements
Module: posit_encoder_16

Interface
REQ-001 Parameter N, default 16: posit width in bits.
REQ-002 Parameter es, default 1: exponent field width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 input_valid  input  1  operand fields valid this cycle.
REQ-006 input_ready  output  1  encoder accepts an operand this cycle.
REQ-007 sign  input  1  sign of the value (1 = negative).
REQ-008 scale  input  8  signed power-of-two exponent, two's complement.
REQ-009 frac  input  16  fraction bits below the hidden 1, MSB-aligned.
REQ-010 sticky  input  1  OR of any discarded bits below frac[0].
REQ-011 in_zero  input  1  value is exactly zero; overrides sign, scale and frac.
REQ-012 in_inf  input  1  value is NaR; overrides all other fields, including in_zero.
REQ-013 r  output  N  encoded posit.
REQ-014 output_valid  output  1  r, inf and zero are valid.
REQ-015 output_ready  input  1  downstream accepts r this cycle.
REQ-016 inf  output  1  r is NaR (0x8000).
REQ-017 zero  output  1  r is 0x0000.

Function
REQ-018 The encoder SHALL be a 2-stage pipeline: stage 1 composes regime, exponent and fraction; stage 2 rounds and applies the sign.
REQ-019 Latency SHALL be exactly 2 cycles from an accepted input (input_valid && input_ready) to output_valid when output_ready stays high.
REQ-020 Stage enables SHALL be: en2 = !v2 || output_ready; en1 = !v1 || en2; input_ready = en1 (combinational, no path from input_valid).
REQ-021 While output_valid && !output_ready, r, inf, zero and output_valid SHALL hold stable; no transfer SHALL be lost or duplicated.
REQ-022 Throughput SHALL be 1 transfer per cycle when output_ready is held high.
REQ-023 Encoding SHALL use k = scale >>> es and e = scale[es-1:0]; regime is k+1 ones then a 0 for k >= 0, and -k zeros then a 1 for k < 0.
REQ-024 The magnitude field SHALL be {regime, e, frac} truncated to N-1 bits; guard = the first dropped bit; sticky' = OR of the remaining dropped bits and sticky.
REQ-025 Rounding SHALL be round-to-nearest-even: increment when guard && (lsb || sticky').
REQ-026 Saturation SHALL apply: scale > 28 or a rounding carry past maxpos gives magnitude 0x7FFF; scale < -28 gives 0x0001; a nonzero input SHALL never encode to 0x0000 or 0x8000.
REQ-027 A negative value SHALL give r = two's complement of the magnitude.
REQ-028 in_inf SHALL give r = 0x8000 with inf = 1; in_zero (without in_inf) SHALL give r = 0x0000 with zero = 1; otherwise inf = zero = 0.
REQ-029 Flags SHALL travel in the pipeline with their operand, with no bypass.

Reset
REQ-030 While rst_n = 0, all valid bits, output_valid, inf and zero SHALL be 0 and r SHALL be 0x0000, independent of clk.
REQ-031 Assertion of rst_n mid-operation SHALL discard all in-flight operands; after release, the first output SHALL come only from an input accepted after release.
REQ-032 input_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-033 Basic values, output_ready = 1:
- sign=0, scale=0, frac=0 -> r=0x4000 two cycles later.
- scale=1 -> 0x5000.
- sign=1, scale=0 -> 0xC000.
- scale=0, frac=0x8000 -> 0x4800.
REQ-034 Rounding at scale=0:
- frac=0x0008, sticky=0 -> 0x4000 (tie rounds to even).
- frac=0x0008, sticky=1 -> 0x4001.
- frac=0x0018 -> 0x4002.
REQ-035 Saturation and specials:
- scale=40 -> 0x7FFF.
- scale=-40 -> 0x0001.
- sign=1, scale=40 -> 0x8001.
- in_zero -> 0x0000 with zero=1.
- in_inf with in_zero -> 0x8000 with inf=1.
REQ-036 Backpressure: stream 5 operands with output_ready held low for cycles 3-6 -> after 2 accepts input_ready = 0; r stays stable while stalled; all 5 results appear in order with none dropped or repeated.
REQ-037 Reset mid-stream: pull rst_n low with 2 operands in flight -> output_valid drops to 0 immediately; after release, no stale result appears and the next operand encodes correctly at 2-cycle latency.

Source files
------------

// File: rtl/posit_encoder_16.sv
// posit_encoder_16: two-stage posit encoder with valid/ready handshaking.
//   Stage 1 builds the regime/exponent/fraction bit string and splits it into
//   the kept magnitude, guard bit and sticky bit. Stage 2 rounds to nearest
//   even, saturates, applies the sign and handles the special values.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   input_valid/ready    operand handshake (input_ready has no path from input_valid)
//   sign, scale, frac    sign, signed power-of-two exponent, fraction below hidden 1
//   sticky               OR of fraction bits already discarded upstream
//   in_zero, in_inf      exact zero / NaR operand (in_inf wins)
//   r                    encoded posit
//   output_valid/ready   result handshake
//   inf, zero            r is NaR / r is zero
module posit_encoder_16 #(
    parameter int unsigned N  = 16,
    parameter int unsigned es = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic         sign,
    input  logic [7:0]   scale,
    input  logic [15:0]  frac,
    input  logic         sticky,
    input  logic         in_zero,
    input  logic         in_inf,
    output logic [N-1:0] r,
    output logic         output_valid,
    input  logic         output_ready,
    output logic         inf,
    output logic         zero
);

    // Full bit string: 2 regime seed bits, exponent, fraction, plus room to shift.
    localparam int unsigned W = 2 + es + 16 + N - 1;
    localparam int MaxScaleI = int'((N - 2) << es);
    localparam logic signed [7:0] MaxScale = 8'(MaxScaleI);
    localparam logic signed [7:0] MinScale = -MaxScale;

    // Pipeline state
    logic         v1_q, v2_q;
    logic         sign1_q, inf1_q, zero1_q;
    logic [N-2:0] mag1_q;
    logic         guard1_q, sticky1_q;
    logic [N-1:0] r_q;
    logic         inf_q, zero_q;

    logic en1, en2;

    always_comb begin
        en2         = !v2_q || output_ready;
        en1         = !v1_q || en2;
        input_ready = en1;
    end

    // Stage 1: regime via arithmetic shift of a two-bit seed. For k >= 0 the
    // seed is 10 shifted by k (k+1 ones, then 0); for k < 0 it is 01 shifted
    // by -k-1 (-k zeros, then 1).
    logic signed [7:0]   scale_s, k;
    logic [es-1:0]       e;
    logic [7:0]          sh;
    logic signed [W-1:0] body, shifted;
    logic [N-2:0]        mag_c;
    logic                guard_c, sticky_c;

    always_comb begin
        scale_s  = $signed(scale);
        k        = scale_s >>> es;
        e        = scale[es-1:0];
        sh       = k[7] ? ~k : k;
        body     = {~k[7], k[7], e, frac, {(N - 1){1'b0}}};
        shifted  = body >>> sh;
        mag_c    = shifted[W-1 -: N-1];
        guard_c  = shifted[W-N];
        sticky_c = (|shifted[W-N-1:0]) | sticky;
        if (scale_s > MaxScale) begin
            mag_c    = '1;
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end else if (scale_s < MinScale) begin
            mag_c    = {{(N - 2){1'b0}}, 1'b1};
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end
    end

    // Stage 2: round to nearest even, clamp a carry out of maxpos, apply sign.
    logic         round_up;
    logic [N-1:0] sum, mag_ext, r_c;

    always_comb begin
        round_up = guard1_q & (mag1_q[0] | sticky1_q);
        sum      = {1'b0, mag1_q} + {{(N - 1){1'b0}}, round_up};
        mag_ext  = sum[N-1] ? {1'b0, {(N - 1){1'b1}}} : sum;
        if (inf1_q) begin
            r_c = {1'b1, {(N - 1){1'b0}}};
        end else if (zero1_q) begin
            r_c = '0;
        end else if (sign1_q) begin
            r_c = -mag_ext;
        end else begin
            r_c = mag_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            sign1_q   <= 1'b0;
            inf1_q    <= 1'b0;
            zero1_q   <= 1'b0;
            mag1_q    <= '0;
            guard1_q  <= 1'b0;
            sticky1_q <= 1'b0;
            v2_q      <= 1'b0;
            r_q       <= '0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            if (en1) begin
                v1_q      <= input_valid;
                sign1_q   <= sign;
                // Flags only set for real operands so bubbles never look special.
                inf1_q    <= input_valid & in_inf;
                zero1_q   <= input_valid & in_zero & ~in_inf;
                mag1_q    <= mag_c;
                guard1_q  <= guard_c;
                sticky1_q <= sticky_c;
            end
            if (en2) begin
                v2_q   <= v1_q;
                r_q    <= r_c;
                inf_q  <= inf1_q;
                zero_q <= zero1_q;
            end
        end
    end

    always_comb begin
        r            = r_q;
        output_valid = v2_q;
        inf          = inf_q;
        zero         = zero_q;
    end

endmodule

// File: tb/tb_posit_encoder_16.sv
// Testbench for posit_encoder_16: directed vectors, a bit-string reference
// model and a scoreboard that checks every completed output transfer.
module tb_posit_encoder_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        input_valid, input_ready;
    logic        sign;
    logic [7:0]  scale;
    logic [15:0] frac;
    logic        sticky, in_zero, in_inf;
    logic [15:0] r;
    logic        output_valid, output_ready;
    logic        inf, zero;

    always #5 clk = ~clk;

    posit_encoder_16 #(.N(16), .es(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .sign         (sign),
        .scale        (scale),
        .frac         (frac),
        .sticky       (sticky),
        .in_zero      (in_zero),
        .in_inf       (in_inf),
        .r            (r),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .inf          (inf),
        .zero         (zero)
    );

    // exp = {inf, zero, r}
    typedef struct packed {
        logic        s;
        logic [7:0]  sc;
        logic [15:0] fr;
        logic        st;
        logic        z;
        logic        nar;
        logic [17:0] exp;
    } vec_t;

    vec_t        vecs [16];
    logic [17:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;
    logic        hold_pending = 1'b0;
    logic [17:0] held;

    function automatic vec_t mk(input logic s, input logic [7:0] sc, input logic [15:0] fr,
                                input logic st, input logic z, input logic nar,
                                input logic [17:0] exp);
        vec_t v;
        v.s = s; v.sc = sc; v.fr = fr; v.st = st; v.z = z; v.nar = nar; v.exp = exp;
        return v;
    endfunction

    // Reference: spell out the posit bit string one bit at a time, keep 15 bits,
    // round on the remainder, saturate, then negate as a 16-bit integer.
    function automatic logic [17:0] model(input logic s, input logic [7:0] sc,
                                          input logic [15:0] fr, input logic st,
                                          input logic z, input logic nar);
        int          scv, k, e, mag;
        bit          bits [$];
        logic        gd, rest;
        logic [15:0] rv;
        if (nar) return 18'h28000;
        if (z) return 18'h10000;
        scv = int'($signed(sc));
        if (scv > 28) begin
            mag = 32767;
        end else if (scv < -28) begin
            mag = 1;
        end else begin
            k = (scv >= 0) ? scv / 2 : -((-scv + 1) / 2);
            e = scv - 2 * k;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[0]);
            for (int i = 15; i >= 0; i--) bits.push_back(fr[i]);
            mag = 0;
            for (int i = 0; i < 15; i++) mag = mag * 2 + int'(bits[i]);
            gd   = bits[15];
            rest = st;
            for (int i = 16; i < bits.size(); i++) rest = rest | bits[i];
            if (gd && ((mag % 2 == 1) || rest)) mag = mag + 1;
            if (mag > 32767) mag = 32767;
        end
        rv = s ? 16'(65536 - mag) : 16'(mag);
        return {2'b00, rv};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard: push expectations on accept, pop and compare on output transfer,
    // and insist that a stalled output stays put.
    task automatic monitor();
        logic [17:0] want;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checks++;
                    if (!output_valid || {inf, zero, r} !== held) begin
                        errors++;
                        $display("FAIL stall_hold got v=%b %h want v=1 %h",
                                 output_valid, {inf, zero, r}, held);
                    end
                end
                hold_pending = 1'b0;
                if (output_valid) begin
                    if (output_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL spurious_output got %h want none", {inf, zero, r});
                        end else begin
                            want = exp_q.pop_front();
                            if ({inf, zero, r} !== want) begin
                                errors++;
                                $display("FAIL result got %h want %h", {inf, zero, r}, want);
                            end
                        end
                    end else begin
                        hold_pending = 1'b1;
                        held = {inf, zero, r};
                    end
                end
                if (input_valid && input_ready) begin
                    exp_q.push_back(model(sign, scale, frac, sticky, in_zero, in_inf));
                    accepts++;
                end
            end
        end
    endtask

    // Present one operand from posedge+1 and return at posedge+1 after its accept edge.
    task automatic drive_op(input vec_t v);
        int n;
        sign = v.s; scale = v.sc; frac = v.fr; sticky = v.st;
        in_zero = v.z; in_inf = v.nar; input_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!input_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!input_ready) check("accept_timeout", 32'(input_ready), 32'd1);
        @(posedge clk);
        #1 input_valid = 1'b0;
    endtask

    task automatic latency_check(input vec_t v);
        int n;
        drive_op(v);
        n = 1;
        while (!output_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'd2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t bp [5];
    int   base;

    initial begin
        vecs[0]  = mk(1'b0, 8'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 18'h04000);
        vecs[1]  = mk(1'b0, 8'd1,  16'h0000, 1'b0, 1'b0, 1'b0, 18'h05000);
        vecs[2]  = mk(1'b1, 8'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 18'h0C000);
        vecs[3]  = mk(1'b0, 8'd0,  16'h8000, 1'b0, 1'b0, 1'b0, 18'h04800);
        vecs[4]  = mk(1'b0, 8'd0,  16'h0008, 1'b0, 1'b0, 1'b0, 18'h04000);
        vecs[5]  = mk(1'b0, 8'd0,  16'h0008, 1'b1, 1'b0, 1'b0, 18'h04001);
        vecs[6]  = mk(1'b0, 8'd0,  16'h0018, 1'b0, 1'b0, 1'b0, 18'h04002);
        vecs[7]  = mk(1'b0, 8'h28, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h07FFF);
        vecs[8]  = mk(1'b0, 8'hD8, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h00001);
        vecs[9]  = mk(1'b1, 8'h28, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h08001);
        vecs[10] = mk(1'b0, 8'd5,  16'h1234, 1'b0, 1'b1, 1'b0, 18'h10000);
        vecs[11] = mk(1'b1, 8'd3,  16'h0000, 1'b0, 1'b1, 1'b1, 18'h28000);
        vecs[12] = mk(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h03000);
        vecs[13] = mk(1'b0, 8'd27, 16'h0001, 1'b0, 1'b0, 1'b0, 18'h07FFF);
        vecs[14] = mk(1'b0, 8'hE5, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h00002);
        vecs[15] = mk(1'b0, 8'd0,  16'hFFF8, 1'b1, 1'b0, 1'b0, 18'h05000);

        input_valid = 1'b0; sign = 1'b0; scale = '0; frac = '0; sticky = 1'b0;
        in_zero = 1'b0; in_inf = 1'b0; output_ready = 1'b1; rst_n = 1'b1;
        fork
            monitor();
        join_none

        // Reset acts before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("reset_state", {28'd0, output_valid, inf, zero, |r}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_after_reset", 32'(input_ready), 32'd1);

        // Pin the model against hand-computed encodings.
        for (int i = 0; i < 16; i++) begin
            check($sformatf("model_pin_%0d", i),
                  32'(model(vecs[i].s, vecs[i].sc, vecs[i].fr, vecs[i].st, vecs[i].z,
                            vecs[i].nar)),
                  32'(vecs[i].exp));
        end

        latency_check(vecs[0]);
        drain();

        // Back-to-back stream at full rate.
        for (int i = 0; i < 16; i++) drive_op(vecs[i]);
        drain();

        // Backpressure: output_ready low for stream cycles 3-6 (1-based).
        bp[0] = vecs[1]; bp[1] = vecs[2]; bp[2] = vecs[5]; bp[3] = vecs[9]; bp[4] = vecs[12];
        base = accepts;
        fork
            begin
                for (int i = 0; i < 5; i++) drive_op(bp[i]);
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    output_ready = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
                    if (c == 2) begin
                        @(negedge clk);
                        check("bp_ready_low", 32'(input_ready), 32'd0);
                        check("bp_accepts", 32'(accepts - base), 32'd2);
                    end
                    @(posedge clk);
                    #1;
                end
                output_ready = 1'b1;
            end
        join
        drain();
        check("bp_total_accepts", 32'(accepts - base), 32'd5);

        // Reset with two operands in flight.
        drive_op(vecs[3]);
        drive_op(vecs[6]);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(output_valid), 32'd0);
        check("rst_mid_r", 32'(r), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_stale_output", 32'(output_valid), 32'd0);
        latency_check(vecs[15]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
